// File: rtl/pong_pkg.sv
// Shared state encodings, default game parameters and score helper for the pong controller.
// Latency: n/a (types and constants only); backpressure: n/a.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int FRAME_DIV_DEF    = 2;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int WIN_SCORE_DEF    = 7;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_frame_div.sv
// Frame-tick prescaler: counts enabled ticks, tc_o fires combinationally on the term_i-th tick and wraps.
// Latency: tc_o same cycle as the terminal tick; backpressure: none, en_i low holds the count.
module pong_frame_div (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] term_i,
  output logic       tc_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       hit;

  assign hit  = en_i && tick_i && (cnt_q == term_i - 8'd1);
  assign tc_o = hit && !clr_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || hit)
      cnt_d = 8'd0;
    else if (en_i && tick_i)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= 8'd0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve hold, physics pacing, scoring and game-over handling.
// Latency: all outputs registered, miss-to-score 1 cycle; backpressure: none, pause freezes physics only.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int FRAME_DIV    = FRAME_DIV_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int WIN_SCORE    = WIN_SCORE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       phys_en,
  output logic       serve,
  output logic       serve_dir,
  output logic [3:0] score_player,
  output logic [3:0] score_opp,
  output logic [2:0] state,
  output logic       game_over,
  output logic       winner
);

  localparam logic [7:0] FD_W  = 8'(FRAME_DIV);
  localparam logic [7:0] SF_W  = 8'(SERVE_FRAMES);
  localparam logic [3:0] WIN_W = 4'(WIN_SCORE);

  state_t     state_q;
  logic [3:0] score_p_q, score_o_q;
  logic       phys_en_q, serve_q, serve_dir_q, game_over_q, winner_q;
  logic       start_low_q;

  logic       div_en, div_clr, div_tc, go_new;
  logic [7:0] div_term;

  // One prescaler shared by the serve hold and the physics pacing; it sits cleared elsewhere.
  always_comb begin
    div_en   = 1'b0;
    div_clr  = 1'b1;
    div_term = SF_W;
    if (state_q == ST_SERVE) begin
      div_en  = 1'b1;
      div_clr = 1'b0;
    end else if (state_q == ST_PLAY) begin
      div_en   = !pause;
      div_clr  = 1'b0;
      div_term = FD_W;
    end
  end

  pong_frame_div u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (frame_tick),
    .en_i   (div_en),
    .clr_i  (div_clr),
    .term_i (div_term),
    .tc_o   (div_tc)
  );

  // A start held from before OVER must drop once before it can begin a new game.
  assign go_new = start && ((state_q == ST_IDLE) || (state_q == ST_OVER && start_low_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      score_p_q   <= 4'd0;
      score_o_q   <= 4'd0;
      phys_en_q   <= 1'b0;
      serve_q     <= 1'b0;
      serve_dir_q <= 1'b1;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      start_low_q <= 1'b0;
    end else begin
      phys_en_q <= 1'b0;
      serve_q   <= 1'b0;
      if (go_new) begin
        state_q     <= ST_SERVE;
        score_p_q   <= 4'd0;
        score_o_q   <= 4'd0;
        serve_dir_q <= 1'b1;
        serve_q     <= 1'b1;
        game_over_q <= 1'b0;
        winner_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_SERVE: if (div_tc) state_q <= ST_PLAY;
          ST_PLAY: begin
            if (miss_left && miss_right) begin
              state_q <= ST_POINT;
            end else if (miss_left) begin
              score_p_q   <= sat_inc(score_p_q, WIN_W);
              serve_dir_q <= 1'b0;
              state_q     <= ST_POINT;
            end else if (miss_right) begin
              score_o_q   <= sat_inc(score_o_q, WIN_W);
              serve_dir_q <= 1'b1;
              state_q     <= ST_POINT;
            end else if (div_tc) begin
              phys_en_q <= 1'b1;
            end
          end
          ST_POINT: begin
            if (score_p_q == WIN_W || score_o_q == WIN_W) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
              winner_q    <= (score_p_q == WIN_W);
              start_low_q <= 1'b0;
            end else begin
              serve_q <= 1'b1;
              state_q <= ST_SERVE;
            end
          end
          ST_OVER: if (!start) start_low_q <= 1'b1;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign phys_en      = phys_en_q;
  assign serve        = serve_q;
  assign serve_dir    = serve_dir_q;
  assign score_player = score_p_q;
  assign score_opp    = score_o_q;
  assign state        = state_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 2: number of frame_tick pulses per physics update, 1..15.
REQ-002 SHALL have parameter SERVE_FRAMES, default 60: frames the ball is held at centre before each serve, 1..255.
REQ-003 SHALL have parameter WIN_SCORE, default 7: points that end the game, 1..15.
REQ-004 clk  in  1  single system clock (pixel clock); all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 frame_tick  in  1  one-cycle pulse per rendered frame, from VGA timing.
REQ-007 start  in  1  level; requests a new game.
REQ-008 pause  in  1  level; freezes play.
REQ-009 miss_left  in  1  one-cycle pulse: ball passed left edge, player scores.
REQ-010 miss_right  in  1  one-cycle pulse: ball passed right edge, opponent scores.
REQ-011 phys_en  out  1  one-cycle pulse enabling one ball/paddle physics step.
REQ-012 serve  out  1  one-cycle pulse: datapath reloads ball to centre.
REQ-013 serve_dir  out  1  ball x direction after serve; 1 = right.
REQ-014 score_player  out  4  player points.
REQ-015 score_opp  out  4  opponent points.
REQ-016 state  out  3  current FSM state encoding.
REQ-017 game_over  out  1  high while in OVER.
REQ-018 winner  out  1  valid in OVER; 1 = player won.

Function
REQ-019 States SHALL be IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; other encodings SHALL return to IDLE on the next cycle.
REQ-020 IDLE: start high SHALL clear both scores, set serve_dir=1, pulse serve, and go to SERVE next cycle.
REQ-021 SERVE: SHALL count frame_tick pulses; on the SERVE_FRAMES-th pulse it SHALL go to PLAY and clear the frame divider.
REQ-022 PLAY: each FRAME_DIV-th frame_tick SHALL produce phys_en in the cycle after that tick; phys_en SHALL never be high outside PLAY.
REQ-023 PLAY with pause high: frame_tick SHALL be ignored (divider holds, no phys_en); miss inputs SHALL still be honoured.
REQ-024 PLAY, miss_left alone: score_player SHALL increment, serve_dir SHALL become 0, and the FSM SHALL go to POINT.
REQ-025 PLAY, miss_right alone: score_opp SHALL increment, serve_dir SHALL become 1, and the FSM SHALL go to POINT.
REQ-026 PLAY, both misses in the same cycle: neither score SHALL change, serve_dir SHALL hold, and the FSM SHALL go to POINT.
REQ-027 Miss pulses outside PLAY SHALL be ignored.
REQ-028 POINT (one cycle): if either score equals WIN_SCORE, the FSM SHALL go to OVER and set winner; otherwise it SHALL pulse serve and go to SERVE with the frame counter cleared.
REQ-029 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-030 OVER: game_over=1; scores and winner SHALL hold; start SHALL act as in IDLE only after start has been seen low at least once since entering OVER.
REQ-031 Outputs SHALL be registered; latency from miss input to score change SHALL be 1 cycle.

Reset
REQ-032 Asynchronous assertion of rst_n SHALL force state=IDLE, scores=0, serve_dir=1, phys_en=serve=game_over=winner=0, and all counters to 0, including mid-serve or mid-play.
REQ-033 Release SHALL take effect on the first clk edge after rst_n rises; no event SHALL be acted on in that cycle.

Structure
REQ-034 The state encodings and the default FRAME_DIV, SERVE_FRAMES and WIN_SCORE values SHALL live in shared package pong_pkg.
REQ-035 The frame prescaler (frame_tick counter, enable, clear, terminal-count pulse) SHALL be sub-module pong_frame_div, instantiated once and reused for both SERVE and PLAY counting.

Verification
REQ-036 Reset, start=1 for 1 cycle, 60 frame_ticks -> serve pulses once, state goes 1 then 2 on the 60th tick, serve_dir=1.
REQ-037 PLAY with FRAME_DIV=2 and 10 frame_ticks -> exactly 5 phys_en pulses, each one cycle after the even-numbered ticks; with pause=1, 0 pulses.
REQ-038 miss_left in PLAY -> score_player=1, serve_dir=0, POINT then SERVE, serve pulses once.
REQ-039 miss_left and miss_right in the same cycle -> scores unchanged, re-serve, serve_dir unchanged.
REQ-040 Seven miss_right events -> score_opp=7, state=4, game_over=1, winner=0; start held high from before OVER is ignored until it drops and reasserts.
REQ-041 rst_n dropped mid-PLAY with score 3:2 -> immediately state=0, scores 0:0, no phys_en.
